// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// Module   : imem_boot_loader_if
// Brief    : Host byte stream, instruction-memory write port and CPU release
//            status for the instruction memory boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  len_err;
  logic [ADDR_WIDTH:0]   words_loaded;

  // Host / bench side
  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, done, len_err, words_loaded
  );

  // Loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, done, len_err, words_loaded
  );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Packs a big-endian byte stream (16-bit length header + words) into
//            instruction memory from address 0, then releases the CPU reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  imem_boot_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [16:0] c_depth = 17'd1 << ADDR_WIDTH;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [7:0]            r_len_hi;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [16:0]           w_len;
  logic                  w_in_ready;
  logic                  w_we;
  logic                  w_cpu_hold;
  logic                  w_done;
  logic                  w_len_err;
  logic                  w_xfer;
  logic                  w_start_ok;

  // Header is zero-extended to 17 bits so LEN == depth is distinguishable
  assign w_len      = {1'b0, r_len_hi, bus.in_data};
  assign w_xfer     = bus.in_valid & w_in_ready;
  assign w_start_ok = bus.start &
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start_ok) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 17'd0)       w_next = S_DONE;
          else if (w_len > c_depth) w_next = S_ERR;
          else                      w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: if (w_xfer) w_next = S_DATA_LO;
      S_DATA_LO: if (w_xfer) w_next = S_WRITE;
      S_WRITE:   w_next = (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? S_DONE : S_DATA_HI;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_we       = 1'b0;
    w_cpu_hold = 1'b1;
    w_done     = 1'b0;
    w_len_err  = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_in_ready = 1'b1;
      S_WRITE: w_we = 1'b1;
      S_DONE: begin
        w_cpu_hold = 1'b0;
        w_done     = 1'b1;
      end
      S_ERR:   w_len_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_len_hi       <= '0;
      r_remaining    <= '0;
      r_words_loaded <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr         <= '0;
        r_words_loaded <= '0;
      end
      if ((r_state == S_LEN_HI) && w_xfer) r_len_hi <= bus.in_data;
      if ((r_state == S_LEN_LO) && w_xfer) r_remaining <= w_len[ADDR_WIDTH:0];
      if ((r_state == S_DATA_HI) && w_xfer) r_wdata[DATA_WIDTH-1 -: 8] <= bus.in_data;
      if ((r_state == S_DATA_LO) && w_xfer) r_wdata[7:0] <= bus.in_data;
      // Address wraps to 0 after a full-depth load; no write follows it
      if (r_state == S_WRITE) begin
        r_addr         <= r_addr + 1'b1;
        r_words_loaded <= r_words_loaded + 1'b1;
        r_remaining    <= r_remaining - 1'b1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.imem_we      = w_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_hold     = w_cpu_hold;
  assign bus.done         = w_done;
  assign bus.len_err      = w_len_err;
  assign bus.words_loaded = r_words_loaded;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Scoreboard bench for imem_boot_loader at ADDR_WIDTH 8 and 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel;
  int         n_vec;
  int         n_err;
  wr_t        q8[$];
  wr_t        q4[$];
  wr_t        e8;
  wr_t        e4;
  logic [7:0] stream [0:5];

  imem_boot_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus8 ();
  imem_boot_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus4 ();

  assign bus8.start    = start & ~sel;
  assign bus8.in_valid = in_valid & ~sel;
  assign bus8.in_data  = in_data;
  assign bus4.start    = start & sel;
  assign bus4.in_valid = in_valid & sel;
  assign bus4.in_data  = in_data;

  logic w_rdy;
  logic w_done;
  assign w_rdy  = sel ? bus4.in_ready : bus8.in_ready;
  assign w_done = sel ? bus4.done : bus8.done;

  imem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8)
  );
  imem_boot_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitors: every imem_we cycle must match the head of its queue
  always @(negedge clk) begin
    if (!reset_n && bus8.imem_we) begin
      n_vec++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL wr8 unexpected write addr=%h data=%h", bus8.imem_addr, bus8.imem_wdata);
      end else begin
        e8 = q8.pop_front();
        if (bus8.imem_addr !== e8.a || bus8.imem_wdata !== e8.d) begin
          n_err++;
          $display("FAIL wr8 got addr=%h data=%h expected addr=%h data=%h",
                   bus8.imem_addr, bus8.imem_wdata, e8.a, e8.d);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n && bus4.imem_we) begin
      n_vec++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL wr4 unexpected write addr=%h data=%h", bus4.imem_addr, bus4.imem_wdata);
      end else begin
        e4 = q4.pop_front();
        if ({4'h0, bus4.imem_addr} !== e4.a || bus4.imem_wdata !== e4.d) begin
          n_err++;
          $display("FAIL wr4 got addr=%h data=%h expected addr=%h data=%h",
                   bus4.imem_addr, bus4.imem_wdata, e4.a, e4.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!w_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!w_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake timeout byte=%h in_ready=%b expected 1", b, w_rdy);
    end
    @(posedge clk);
    if (gap > 0) begin
      @(negedge clk) in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic end_stream();
    @(negedge clk) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!w_done && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!w_done) begin
      n_vec++;
      n_err++;
      $display("FAIL done timeout done=%b expected 1", w_done);
    end
  endtask

  task automatic check_reset8(input string tag);
    check({tag, " in_ready"},     32'(bus8.in_ready),     32'd0);
    check({tag, " imem_we"},      32'(bus8.imem_we),      32'd0);
    check({tag, " imem_addr"},    32'(bus8.imem_addr),    32'd0);
    check({tag, " imem_wdata"},   32'(bus8.imem_wdata),   32'd0);
    check({tag, " cpu_hold"},     32'(bus8.cpu_hold),     32'd1);
    check({tag, " done"},         32'(bus8.done),         32'd0);
    check({tag, " len_err"},      32'(bus8.len_err),      32'd0);
    check({tag, " words_loaded"}, 32'(bus8.words_loaded), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset8("reset");
    check("reset4 cpu_hold", 32'(bus4.cpu_hold), 32'd1);
    reset_n = 1'b0;

    // Basic two-word load, then the same stream with 3-cycle gaps
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    for (int g = 0; g <= 3; g += 3) begin
      q8.push_back('{8'h00, 16'h1234});
      q8.push_back('{8'h01, 16'hABCD});
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(stream[i], g);
      end_stream();
      wait_done();
      check($sformatf("load gap%0d done", g),     32'(bus8.done),         32'd1);
      check($sformatf("load gap%0d cpu_hold", g), 32'(bus8.cpu_hold),     32'd0);
      check($sformatf("load gap%0d words", g),    32'(bus8.words_loaded), 32'd2);
      check($sformatf("load gap%0d pending", g),  32'(q8.size()),         32'd0);
    end

    // Zero length: DONE on the cycle after the LEN_LO transfer, no write
    pulse_start();
    check("reload cpu_hold", 32'(bus8.cpu_hold), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    end_stream();
    check("zero done",     32'(bus8.done),         32'd1);
    check("zero cpu_hold", 32'(bus8.cpu_hold),     32'd0);
    check("zero words",    32'(bus8.words_loaded), 32'd0);

    // LEN = 0x101 exceeds 256-word memory
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    end_stream();
    check("err len_err",  32'(bus8.len_err),  32'd1);
    check("err in_ready", 32'(bus8.in_ready), 32'd0);
    check("err cpu_hold", 32'(bus8.cpu_hold), 32'd1);
    check("err done",     32'(bus8.done),     32'd0);
    q8.push_back('{8'h00, 16'h5555});
    pulse_start();
    check("recover len_err", 32'(bus8.len_err), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h55, 0);
    end_stream();
    wait_done();
    check("recover words",   32'(bus8.words_loaded), 32'd1);
    check("recover pending", 32'(q8.size()),         32'd0);

    // Full depth on the 16-word instance; address wraps, no 17th write
    sel = 1'b1;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      d = 16'hC000 + 16'(i) * 16'h0111;
      q4.push_back('{8'(i), d});
      send_byte(d[15:8], 0);
      send_byte(d[7:0], 0);
    end
    end_stream();
    wait_done();
    check("full words",     32'(bus4.words_loaded), 32'd16);
    check("full done",      32'(bus4.done),         32'd1);
    check("full addr wrap", 32'(bus4.imem_addr),    32'd0);
    repeat (4) @(negedge clk);
    check("full pending",   32'(q4.size()),         32'd0);
    sel = 1'b0;

    // Reset after the high byte of word 1
    q8.push_back('{8'h00, 16'h1122});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check_reset8("midreset");
    @(negedge clk) reset_n = 1'b0;
    q8.push_back('{8'h00, 16'hAABB});
    q8.push_back('{8'h01, 16'hCCDD});
    stream = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    end_stream();
    wait_done();
    check("after reset words",   32'(bus8.words_loaded), 32'd2);
    check("after reset cpu_hold", 32'(bus8.cpu_hold),    32'd0);
    repeat (3) @(negedge clk);
    check("final pending8", 32'(q8.size()), 32'd0);
    check("final pending4", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Writer-side counterpart to the CPU instruction fetch path.
- Accepts a byte stream from a host or bench and packs each pair of bytes into a 16-bit instruction word.
- Writes each word into instruction memory at sequential addresses starting at 0.
- Holds the CPU in reset until the whole program has been written, then releases it so fetch begins at PC 0.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width; memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction word width; fixed at 2 bytes per word.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous reset, active-high: asserted when 1, regardless of the port name.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  the byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  write address.
- imem_wdata  output  DATA_WIDTH  write data.
- cpu_hold  output  1  drive into the CPU reset; 1 keeps the CPU in reset.
- done  output  1  program loaded; CPU released.
- len_err  output  1  header word count exceeds memory depth.
- words_loaded  output  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
- **Reset values** (asynchronous, while reset_n=1):
  - state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, len_err=0, words_loaded=0.
  - Internal remaining count=0.
- **Handshake:** a byte transfers on a posedge where in_valid=1 and in_ready=1. in_ready is decoded from the registered state only; it never depends on in_valid.
- **Stream format:** big-endian throughout.
  - Byte 0 = LEN[15:8], byte 1 = LEN[7:0].
  - Then LEN words, each sent as high byte followed by low byte.
- **IDLE:** in_ready=0, cpu_hold=1. start -> LEN_HI; clear words_loaded and imem_addr.
- **LEN_HI:** in_ready=1. On transfer, latch LEN[15:8] -> LEN_LO.
- **LEN_LO:** in_ready=1. On transfer, latch LEN[7:0], then:
  - LEN=0 -> DONE.
  - LEN > 2**ADDR_WIDTH -> ERR.
  - otherwise remaining=LEN -> DATA_HI.
- **DATA_HI:** in_ready=1. On transfer, imem_wdata[15:8] <= in_data -> DATA_LO.
- **DATA_LO:** in_ready=1. On transfer, imem_wdata[7:0] <= in_data -> WRITE.
- **WRITE:** in_ready=0, imem_we=1 for exactly this one cycle, with the current imem_addr/imem_wdata.
  - On exit: imem_addr++, words_loaded++, remaining--.
  - remaining reaching 0 -> DONE, else DATA_HI.
- **Latency:** imem_we is high in the cycle after the low-byte transfer. Peak throughput is 1 word per 3 cycles.
- **Address wrap:** LEN = 2**ADDR_WIDTH fills memory exactly. imem_addr wraps to 0 after the last write but no further write occurs. words_loaded reaches 2**ADDR_WIDTH.
- **DONE:** cpu_hold=0, done=1, in_ready=0. start -> LEN_HI with cpu_hold=1 and done=0 from the next cycle (reload).
- **ERR:** len_err=1, cpu_hold=1, in_ready=0, imem_we never asserted. start -> LEN_HI and clears len_err.
- **start during LEN_HI..WRITE:** ignored; the load in progress continues unchanged.
- **in_valid gaps:** the FSM waits indefinitely in any accepting state with no side effects.
- **Reset mid-load:** all outputs return to reset values immediately and the partial program is abandoned. Words already written stay in memory, but cpu_hold=1 prevents execution.
- **Width rules:** LEN is compared as a 17-bit unsigned value against 2**ADDR_WIDTH. remaining is ADDR_WIDTH+1 bits.

Test Plan:
- **Basic load:** reset_n 1->0, start, stream 00 02 12 34 AB CD with in_valid held 1.
  - imem_we pulses twice: addr 0 data 1234, then addr 1 data ABCD.
  - done=1, cpu_hold=0, words_loaded=2.
- **Backpressure gaps:** same stream with in_valid=0 for 3 cycles between every byte.
  - Identical writes; exactly one imem_we per word; no write while in_valid=0.
- **Zero length:** start, stream 00 00 -> DONE one cycle after LEN_LO; imem_we never asserted; cpu_hold=0.
- **Length error:** ADDR_WIDTH=8, stream 01 01 -> len_err=1, in_ready=0, cpu_hold=1.
  - A following start and stream 00 01 5555 recovers: len_err=0, one write at addr 0.
- **Full depth:** ADDR_WIDTH=4, LEN=0010, 16 words -> addrs 0..F written.
  - words_loaded=16, done=1, no 17th write.
- **Reset mid-load:** assert reset_n=1 after the high byte of word 1 -> all outputs at reset values, in_ready=0.
  - After release, a new start and full stream load correctly from addr 0.
